// File: rtl/agc_pkg.sv
// Shared types and default timing for the auto-gain control path: gain codes,
// relay sequencer states and the relay/settle/dwell delays at 200 MHz.
package agc_pkg;

    typedef enum logic [1:0] {
        GAIN_3     = 2'd0,
        GAIN_6_5   = 2'd1,
        GAIN_13_5  = 2'd2,
        GAIN_29_25 = 2'd3
    } gain_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_CLEAR,
        ST_WAIT_CLR,
        ST_SET,
        ST_WAIT_SET,
        ST_SETTLE,
        ST_DWELL
    } seq_state_e;

    localparam int RELAY_DELAY_CYC_DEF = 1_000_000;
    localparam int SETTLE_CYC_DEF      = 400_000;
    localparam int MIN_DWELL_CYC_DEF   = 2_000_000;
    localparam int CNT_W_DEF           = 24;

endpackage

// File: rtl/relay_gain_sequencer_if.sv
// Request handshake and relay/status signals of the gain relay sequencer.
// switch_count exists only when RELAY_SWITCH_CNT_EN is defined.
interface relay_gain_sequencer_if;

    logic       req_valid;
    logic [1:0] req_gain;
    logic       req_ready;
    logic [1:0] relay_ctrl;
    logic [1:0] cur_gain;
    logic       busy;
    logic       blank;
    logic       settled;
`ifdef RELAY_SWITCH_CNT_EN
    logic [15:0] switch_count;
`endif

    modport master (
        output req_valid, req_gain,
        input  req_ready, relay_ctrl, cur_gain, busy, blank, settled
`ifdef RELAY_SWITCH_CNT_EN
        , input switch_count
`endif
    );

    modport slave (
        input  req_valid, req_gain,
        output req_ready, relay_ctrl, cur_gain, busy, blank, settled
`ifdef RELAY_SWITCH_CNT_EN
        , output switch_count
`endif
    );

endinterface

// File: rtl/relay_gain_sequencer_delay_counter.sv
// Shared down-counter for the sequencer wait states: load N-1, done while zero.
module delay_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - CNT_W'(1);
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/relay_gain_sequencer.sv
// Drives the two gain relay coils clear-before-set, with actuation, settling and
// dwell timing. Define RELAY_SWITCH_CNT_EN to add the saturating switch_count.
module relay_gain_sequencer
    import agc_pkg::*;
#(
    parameter int RELAY_DELAY_CYC = RELAY_DELAY_CYC_DEF,
    parameter int SETTLE_CYC      = SETTLE_CYC_DEF,
    parameter int MIN_DWELL_CYC   = MIN_DWELL_CYC_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    relay_gain_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] RELAY_LOAD  = CNT_W'(RELAY_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = CNT_W'(MIN_DWELL_CYC - 1);

    seq_state_e       state_q, state_d;
    gain_e            tgt_q;
    gain_e            cur_q;
    logic [1:0]       relay_q;
    logic             settled_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;
    logic             accept;
    logic             same_gain;
    logic             settle_exit;

    assign accept      = (state_q == ST_IDLE) && bus.req_valid;
    assign same_gain   = (bus.req_gain == cur_q);
    assign settle_exit = (state_q == ST_SETTLE) && cnt_done;

    delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (same_gain)
                        state_d = ST_ACK;
                    else if ((relay_q & ~bus.req_gain) != 2'b00)
                        state_d = ST_CLEAR;
                    else
                        state_d = ST_SET;
                end
            end
            ST_ACK:   state_d = ST_IDLE;
            ST_CLEAR: begin
                cnt_load = 1'b1;
                cnt_val  = RELAY_LOAD;
                state_d  = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (cnt_done) begin
                    // Relay still lacks some target bits: a set phase follows.
                    if ((tgt_q & ~relay_q) != 2'b00) begin
                        state_d = ST_SET;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = SETTLE_LOAD;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_SET: begin
                cnt_load = 1'b1;
                cnt_val  = RELAY_LOAD;
                state_d  = ST_WAIT_SET;
            end
            ST_WAIT_SET: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = DWELL_LOAD;
                    state_d  = ST_DWELL;
                end
            end
            ST_DWELL: if (cnt_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tgt_q     <= GAIN_3;
            cur_q     <= GAIN_3;
            relay_q   <= 2'b00;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settled_q <= (accept && same_gain) || settle_exit;
            if (accept)
                tgt_q <= gain_e'(bus.req_gain);
            if (settle_exit)
                cur_q <= tgt_q;
            if (state_q == ST_CLEAR)
                relay_q <= relay_q & tgt_q;
            else if (state_q == ST_SET)
                relay_q <= tgt_q;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_ACK);
    assign bus.blank      = (state_q == ST_CLEAR) || (state_q == ST_WAIT_CLR) ||
                            (state_q == ST_SET)   || (state_q == ST_WAIT_SET) ||
                            (state_q == ST_SETTLE);
    assign bus.settled    = settled_q;
    assign bus.relay_ctrl = relay_q;
    assign bus.cur_gain   = cur_q;

`ifdef RELAY_SWITCH_CNT_EN
    logic [15:0] sw_cnt_q;
    logic        coil_changed;

    assign coil_changed = ((state_q == ST_CLEAR) && ((relay_q & tgt_q) != relay_q)) ||
                          ((state_q == ST_SET)   && (tgt_q != relay_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sw_cnt_q <= '0;
        else if (coil_changed && (sw_cnt_q != 16'hFFFF))
            sw_cnt_q <= sw_cnt_q + 16'd1;
    end

    assign bus.switch_count = sw_cnt_q;
`endif

endmodule

// File: tb/tb_relay_gain_sequencer.sv
// Directed bench for relay_gain_sequencer with shortened delays (4/3/5 cycles).
module tb_relay_gain_sequencer;

    localparam int RELAY  = 4;
    localparam int SETTLE = 3;
    localparam int DWELL  = 5;
    // Blank length after accept: one coil phase, or clear phase plus set phase.
    localparam int T_ONE  = 1 + RELAY + SETTLE;
    localparam int T_TWO  = 1 + RELAY + 1 + RELAY + SETTLE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    int         blank_cyc, settled_cnt, settled_at, ready_low, busy_cyc;
    logic [3:0] seen;
    logic [1:0] relay_k2;

    relay_gain_sequencer_if bus ();

    relay_gain_sequencer #(
        .RELAY_DELAY_CYC (RELAY),
        .SETTLE_CYC      (SETTLE),
        .MIN_DWELL_CYC   (DWELL),
        .CNT_W           (24)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("ready_timeout", 32'(bus.req_ready), 32'd1);
    endtask

    // Issue one request and record per-cycle activity until req_ready returns.
    // req_gain is flipped right after the accept edge to prove it was latched.
    task automatic run_txn(input logic [1:0] g, input bit hold);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_gain  = g;
        @(posedge clk); #1;
        bus.req_gain = g ^ 2'b11;
        if (!hold) bus.req_valid = 1'b0;
        blank_cyc = 0; settled_cnt = 0; settled_at = 0;
        ready_low = 0; busy_cyc = 0; seen = '0; relay_k2 = 2'b00;
        for (int k = 1; k <= 100; k++) begin
            blank_cyc   += int'(bus.blank);
            settled_cnt += int'(bus.settled);
            busy_cyc    += int'(bus.busy);
            ready_low   += int'(!bus.req_ready);
            if (bus.settled) settled_at = k;
            if (k == 2) relay_k2 = bus.relay_ctrl;
            seen[bus.relay_ctrl] = 1'b1;
            if (bus.req_ready) break;
            if (k == 100) check("txn_timeout", 32'(bus.req_ready), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef RELAY_SWITCH_CNT_EN
        logic [15:0] sw_before;
`endif
        bus.req_valid = 1'b0;
        bus.req_gain  = 2'b00;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_relay",   32'(bus.relay_ctrl), 32'd0);
        check("rst_cur",     32'(bus.cur_gain),   32'd0);
        check("rst_ready",   32'(bus.req_ready),  32'd1);
        check("rst_blank",   32'(bus.blank),      32'd0);
        check("rst_busy",    32'(bus.busy),       32'd0);
        check("rst_settled", 32'(bus.settled),    32'd0);

        // 00 -> 11: set phase only
        run_txn(2'd3, 1'b0);
        check("t1_blank",   blank_cyc,   T_ONE);
        check("t1_settled", settled_cnt, 1);
        check("t1_set_at",  settled_at,  T_ONE + 1);
        check("t1_rdy_low", ready_low,   T_ONE + DWELL);
        check("t1_busy",    busy_cyc,    T_ONE + DWELL);
        check("t1_relay2",  32'(relay_k2), 32'd3);
        check("t1_seen",    32'(seen),   32'b1001);
        check("t1_cur",     32'(bus.cur_gain), 32'd3);

        // 11 -> 01: clear phase only
        run_txn(2'd1, 1'b0);
        check("t2_blank",  blank_cyc,     T_ONE);
        check("t2_relay2", 32'(relay_k2), 32'd1);
        check("t2_seen",   32'(seen),     32'b1010);
        check("t2_cur",    32'(bus.cur_gain), 32'd1);

        // 01 -> 10: passes through 00, never 11
`ifdef RELAY_SWITCH_CNT_EN
        sw_before = bus.switch_count;
`endif
        run_txn(2'd2, 1'b0);
        check("t3_blank",   blank_cyc,     T_TWO);
        check("t3_settled", settled_cnt,   1);
        check("t3_set_at",  settled_at,    T_TWO + 1);
        check("t3_rdy_low", ready_low,     T_TWO + DWELL);
        check("t3_relay2",  32'(relay_k2), 32'd0);
        check("t3_seen",    32'(seen),     32'b0111);
        check("t3_cur",     32'(bus.cur_gain), 32'd2);
`ifdef RELAY_SWITCH_CNT_EN
        check("t3_swcnt", 32'(bus.switch_count - sw_before), 32'd2);
`endif

        // 10 -> 01
        run_txn(2'd1, 1'b0);
        check("t4_blank", blank_cyc, T_TWO);
        check("t4_seen",  32'(seen), 32'b0111);
        check("t4_cur",   32'(bus.cur_gain), 32'd1);

        // 01 -> 01: immediate settled pulse, nothing else moves
        run_txn(2'd1, 1'b0);
        check("t5_blank",   blank_cyc,   0);
        check("t5_busy",    busy_cyc,    0);
        check("t5_settled", settled_cnt, 1);
        check("t5_set_at",  settled_at,  1);
        check("t5_rdy_low", ready_low,   1);
        check("t5_seen",    32'(seen),   32'b0010);

        // 01 -> 00 with req_valid held; the held request (now gain 3) is taken on IDLE entry
        run_txn(2'd0, 1'b1);
        check("t6_blank", blank_cyc, T_ONE);
        check("t6_seen",  32'(seen), 32'b0011);
        check("t6_cur",   32'(bus.cur_gain), 32'd0);
        @(posedge clk); #1;
        check("t6_hold_ready", 32'(bus.req_ready), 32'd0);
        check("t6_hold_busy",  32'(bus.busy),      32'd1);
        bus.req_valid = 1'b0;
        wait_ready();
        check("t6_hold_cur", 32'(bus.cur_gain), 32'd3);

        // Reset during WAIT_SET of 00 -> 10
        run_txn(2'd0, 1'b0);
        check("t7_cur0", 32'(bus.cur_gain), 32'd0);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_gain  = 2'd2;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t7_wait_set_relay", 32'(bus.relay_ctrl), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t7_rst_relay", 32'(bus.relay_ctrl), 32'd0);
        check("t7_rst_ready", 32'(bus.req_ready),  32'd1);
        check("t7_rst_blank", 32'(bus.blank),      32'd0);
        check("t7_rst_busy",  32'(bus.busy),       32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("t7_post_ready", 32'(bus.req_ready),  32'd1);
        check("t7_post_relay", 32'(bus.relay_ctrl), 32'd0);
        run_txn(2'd2, 1'b0);
        check("t7_again_blank", blank_cyc, T_ONE);
        check("t7_again_cur",   32'(bus.cur_gain), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/relay_gain_sequencer.md
Name: relay_gain_sequencer

Overview:
- Sits between the auto-gain decision logic and the front-end gain relays, in the `clk` (200 MHz) domain.
- Accepts gain-change requests over a valid/ready handshake and drives the two relay coils in a safe order, so that no intermediate state gives a gain above max(old, new).
- Enforces relay actuation time, analog settling time and a minimum dwell between changes.
- Outputs an ADC blanking flag and a one-cycle settled pulse, so downstream peak detection discards transient samples.

Parameters:
- RELAY_DELAY_CYC, 1_000_000, cycles held after each coil change for contact actuation (5 ms at 200 MHz); must be ≥1.
- SETTLE_CYC, 400_000, cycles of analog settling after the final coil change (2 ms); must be ≥1.
- MIN_DWELL_CYC, 2_000_000, cycles req_ready stays low after a completed change (10 ms); must be ≥1.
- CNT_W, 24, width of the shared delay counter; must hold the largest delay.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  gain-change request valid
- req_gain  in  2  target gain code: 0=3x, 1=6.5x, 2=13.5x, 3=29.25x
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid && req_ready
- relay_ctrl  out  2  relay coil drive; the code equals the gain index
- cur_gain  out  2  gain index currently applied and settled
- busy  out  1  high from the accept cycle until DWELL ends
- blank  out  1  ADC data invalid; high from the cycle after accept through the last SETTLE cycle
- settled  out  1  one-cycle pulse when the new gain is valid
- switch_count  out  16  only with RELAY_SWITCH_CNT_EN

Behaviour:
- Reset (asynchronous, active-low, fixed): state=IDLE, relay_ctrl=2'b00, cur_gain=0, busy=0, blank=0, settled=0, req_ready=1 on the first clock after release, counter=0.
- Reset mid-sequence aborts immediately; relays drop to 00 (lowest gain, safe).
- On accept: latch tgt=req_gain; compute clr = relay_ctrl & ~tgt and set = tgt & ~relay_ctrl.
- IDLE: req_ready=1.
  - Accept with tgt==cur_gain: settled pulses the next cycle; no blank, no dwell; return to IDLE (req_ready low for that one cycle).
  - Otherwise go to CLEAR if clr≠0, else SET.
- CLEAR: relay_ctrl <= relay_ctrl & tgt (all 1→0 bits drop together); load counter; go to WAIT_CLR.
- WAIT_CLR: held exactly RELAY_DELAY_CYC cycles; then go to SET if set≠0, else SETTLE.
- SET: relay_ctrl <= tgt; load counter; go to WAIT_SET.
- WAIT_SET: held exactly RELAY_DELAY_CYC cycles; then SETTLE.
- SETTLE: held exactly SETTLE_CYC cycles. On exit: cur_gain<=tgt, blank falls, settled pulses for one cycle, go to DWELL.
- DWELL: held exactly MIN_DWELL_CYC cycles with req_ready=0; then IDLE.
- Ordering rule: clear-before-set guarantees intermediate codes are below the larger endpoint. Examples: 01→10 passes through 00; 10→01 passes through 00; 00→11 is one SET step only.
- req_valid held during busy is ignored, not queued. The requester keeps it asserted and is accepted on re-entry to IDLE.
- req_gain is sampled only on the accept cycle; later changes have no effect.
- Counter is one shared down-counter: load N−1, exit when it reaches 0. Total latency for a two-phase change = 1+RELAY+1+RELAY+SETTLE cycles after accept.
- Illegal/unreached state codes → IDLE with relay_ctrl unchanged.

Optional Feature:
- Macro RELAY_SWITCH_CNT_EN.
- Defined: port switch_count exists. It holds a 16-bit saturating count of coil writes that changed relay_ctrl (CLEAR or SET each count 1), stops at 16'hFFFF, and resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package agc_pkg holds:
  - gain index typedef (2-bit enum GAIN_3..GAIN_29_25)
  - sequencer state enum
  - default delay constants
- The same package is reused by the gain-decision logic.
- Sub-module delay_counter (load value, load strobe, done flag, CNT_W param) is natural; it is instantiated once and shared by all wait states.

Test Plan (small params: RELAY=4, SETTLE=3, DWELL=5):
- Reset release → relay_ctrl=00, cur_gain=0, req_ready=1, blank=0, busy=0.
- Request 00→11 → no CLEAR phase; relay_ctrl=11 one cycle after accept; blank high 1+4+3 cycles; settled pulses once; cur_gain=3; req_ready low 5 more cycles.
- From 01, request 2 → relay_ctrl sequence 01→00 (4 cycles)→10; value 11 never appears; cur_gain=2 after settle.
- From 10, request 1 → sequence 10→00→01; 11 never seen.
- Request equal to cur_gain → settled pulse next cycle; relay_ctrl, blank and busy unchanged.
- req_valid held during DWELL → accepted on the first IDLE cycle.
- rst_n low during WAIT_SET → relay_ctrl=00 asynchronously; FSM in IDLE after release.
- With RELAY_SWITCH_CNT_EN, 01→10 increments switch_count by 2; preloaded 16'hFFFF stays saturated.
